// File: rtl/hazard_pkg.sv
// Shared types and operand source codes for the decode-stage hazard scoreboard.
package hazard_pkg;

    localparam logic [2:0] SRC_RF   = 3'd0;
    localparam logic [2:0] SRC_AU0  = 3'd1;
    localparam logic [2:0] SRC_AU1  = 3'd2;
    localparam logic [2:0] SRC_MUL0 = 3'd3;
    localparam logic [2:0] SRC_MUL1 = 3'd4;
    localparam logic [2:0] SRC_LSU  = 3'd5;
    localparam logic [2:0] SRC_WB0  = 3'd6;
    localparam logic [2:0] SRC_WB1  = 3'd7;

    typedef enum logic [1:0] {
        UNIT_AU   = 2'd0,
        UNIT_MUL  = 2'd1,
        UNIT_LSU  = 2'd2,
        UNIT_NONE = 2'd3
    } unit_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_EXEC = 2'd2,
        ST_WB   = 2'd3
    } ent_state_e;

    // In WB the lane field holds the write-back lane, not the issue lane.
    typedef struct packed {
        ent_state_e state;
        unit_e      unit;
        logic       lane;
    } entry_t;

endpackage

// File: rtl/hazard_scoreboard_entry.sv
// One architectural register's scoreboard entry.
//
//   state   | meaning
//   --------+--------------------------------------------------------
//   IDLE    | no pending producer, operand comes from the regfile
//   WAIT    | MUL/LSU producer in flight, result not yet available
//   EXEC    | AU producer in execute, bypass from the AU lane
//   WB      | result in write-back, bypass from the WB lane
module sb_entry
    import hazard_pkg::*;
#(
    parameter int REG_ADDR_W = 5,
    parameter int IDX        = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  issue_i,
    input  unit_e                 issue_unit_i,
    input  logic                  issue_lane_i,
    input  logic                  mul_done_i,
    input  logic [REG_ADDR_W-1:0] mul_done_rd_i,
    input  logic                  mul_done_lane_i,
    input  logic                  lsu_done_i,
    input  logic [REG_ADDR_W-1:0] lsu_done_rd_i,
    output entry_t                entry_o,
    output logic                  hit_o
);

    localparam logic [REG_ADDR_W-1:0] MY_IDX = REG_ADDR_W'(IDX);

    entry_t ent_q, ent_d;

    // A completion pulse only counts when it targets this register and its unit.
    assign hit_o = (ent_q.state == ST_WAIT) &&
                   (((ent_q.unit == UNIT_MUL) && mul_done_i && (mul_done_rd_i == MY_IDX)) ||
                    ((ent_q.unit == UNIT_LSU) && lsu_done_i && (lsu_done_rd_i == MY_IDX)));

    assign entry_o = ent_q;

    // Entry state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ent_q <= '{state: ST_IDLE, unit: UNIT_AU, lane: 1'b0};
        end else begin
            ent_q <= ent_d;
        end
    end

    // Next-state: pipeline progression, with a new issue taking priority.
    always_comb begin
        ent_d = ent_q;
        unique case (ent_q.state)
            ST_EXEC: ent_d.state = ST_WB;
            ST_WAIT: begin
                if (hit_o) begin
                    ent_d.state = ST_WB;
                    ent_d.lane  = (ent_q.unit == UNIT_MUL) ? mul_done_lane_i : 1'b0;
                end
            end
            ST_WB:   ent_d.state = ST_IDLE;
            default: ;
        endcase
        if (issue_i) begin
            ent_d.state = (issue_unit_i == UNIT_AU) ? ST_EXEC : ST_WAIT;
            ent_d.unit  = issue_unit_i;
            ent_d.lane  = (issue_unit_i == UNIT_LSU) ? 1'b0 : issue_lane_i;
        end
    end

endmodule

// File: rtl/hazard_scoreboard.sv
// Register scoreboard and forwarding controller beside instruction decode.
module hazard_scoreboard
    import hazard_pkg::*;
#(
    parameter int REG_COUNT  = 32,
    parameter int REG_ADDR_W = 5
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  dec_valid,
    input  logic [REG_ADDR_W-1:0] dec_rs1,
    input  logic [REG_ADDR_W-1:0] dec_rs2,
    input  logic                  dec_use_rs2,
    input  logic                  dec_reg_write,
    input  logic [REG_ADDR_W-1:0] dec_rd,
    input  logic [1:0]            dec_unit,
    input  logic                  dec_lane,
    input  logic                  mul_done,
    input  logic [REG_ADDR_W-1:0] mul_done_rd,
    input  logic                  mul_done_lane,
    input  logic                  lsu_done,
    input  logic [REG_ADDR_W-1:0] lsu_done_rd,
    output logic [2:0]            hazard_select1,
    output logic [2:0]            hazard_select2,
    output logic                  stall,
    output logic [REG_COUNT-1:0]  busy_mask
);

    entry_t               ent [REG_COUNT];
    logic [REG_COUNT-1:0] hit;
    logic [REG_COUNT-1:0] issue_vec;
    logic                 issue;
    logic                 waw;
    logic [3:0]           src1, src2;

    // Returns {ready, source code} for one operand.
    function automatic logic [3:0] operand_src(entry_t e, logic h, logic mul_lane);
        logic [3:0] r;
        r = {1'b1, SRC_RF};
        unique case (e.state)
            ST_EXEC: if (e.unit == UNIT_AU) r = {1'b1, e.lane ? SRC_AU1 : SRC_AU0};
            ST_WB:   r = {1'b1, e.lane ? SRC_WB1 : SRC_WB0};
            ST_WAIT: begin
                if (!h)                        r = {1'b0, SRC_RF};
                else if (e.unit == UNIT_LSU)   r = {1'b1, SRC_LSU};
                else                           r = {1'b1, mul_lane ? SRC_MUL1 : SRC_MUL0};
            end
            default: ;
        endcase
        return r;
    endfunction

    // x0 is hardwired: always idle, never hit, never issued.
    assign ent[0]       = '{state: ST_IDLE, unit: UNIT_NONE, lane: 1'b0};
    assign hit[0]       = 1'b0;
    assign issue_vec[0] = 1'b0;
    assign busy_mask[0] = 1'b0;

    for (genvar g = 1; g < REG_COUNT; g++) begin : g_entry
        assign issue_vec[g] = issue && (dec_rd == REG_ADDR_W'(g));
        assign busy_mask[g] = (ent[g].state != ST_IDLE);

        sb_entry #(
            .REG_ADDR_W (REG_ADDR_W),
            .IDX        (g)
        ) u_entry (
            .clk             (clk),
            .rst_n           (rst_n),
            .issue_i         (issue_vec[g]),
            .issue_unit_i    (unit_e'(dec_unit)),
            .issue_lane_i    (dec_lane),
            .mul_done_i      (mul_done),
            .mul_done_rd_i   (mul_done_rd),
            .mul_done_lane_i (mul_done_lane),
            .lsu_done_i      (lsu_done),
            .lsu_done_rd_i   (lsu_done_rd),
            .entry_o         (ent[g]),
            .hit_o           (hit[g])
        );
    end

    // Operand selects, stall and issue decode, all same-cycle.
    always_comb begin
        src1  = operand_src(ent[dec_rs1], hit[dec_rs1], mul_done_lane);
        src2  = operand_src(ent[dec_rs2], hit[dec_rs2], mul_done_lane);
        waw   = dec_reg_write && (ent[dec_rd].state == ST_WAIT) && !hit[dec_rd];
        stall = dec_valid && (!src1[3] || (dec_use_rs2 && !src2[3]) || waw);
        issue = dec_valid && !stall && dec_reg_write && (dec_rd != '0) &&
                (unit_e'(dec_unit) != UNIT_NONE);
        hazard_select1 = dec_valid ? src1[2:0] : SRC_RF;
        hazard_select2 = (dec_valid && dec_use_rs2) ? src2[2:0] : SRC_RF;
    end

endmodule
